serial_sub_ctrl: RTL
====================

Name: serial_sub_ctrl

Overview:
Bit-serial subtractor sequencer. It computes a - b - bin on two WIDTH-bit operands using a single 1-bit full-subtractor cell and a registered borrow. The cell processes one bit per cycle, LSB first. Operand/result moves use a start/ready/busy/done handshake, so slow control paths can reuse the one-bit subtract datapath instead of a wide ripple subtractor.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2).
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when ready=1.
a  input  WIDTH  minuend; captured on an accepted start.
b  input  WIDTH  subtrahend; captured on an accepted start.
bin  input  1  borrow-in; captured on an accepted start.
ready  output  1  high in IDLE only.
busy  output  1  high in SHIFT only.
done  output  1  one-cycle pulse when the result is valid.
diff  output  WIDTH  result; held from done until the next accepted start.
bout  output  1  final borrow-out; held like diff.

Behaviour:
- Reset (rst=1 at an edge), including mid-operation:
  - state=IDLE; ready=1; busy=0; done=0; diff=0; bout=0.
  - Shift registers, count and borrow register cleared.
  - No done pulse for the aborted operation.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge → latch a and b into shift regs, borrow_r=bin, count=0, diff=0, go to SHIFT.
  - start=0 → stay in IDLE.
- SHIFT, each edge:
  - d = a_sr[0] ^ b_sr[0] ^ borrow_r.
  - borrow_r = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow_r).
  - diff = {d, diff[WIDTH-1:1]}; a_sr and b_sr shift right by one; count++.
  - When count reaches WIDTH-1 on this edge, go to DONE and load bout from the final borrow.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start while busy or in DONE is ignored; there is no queueing and in-flight operands are not disturbed.
- Latency: start accepted at edge k → done high in the cycle after edge k+WIDTH. Back-to-back period is WIDTH+2 cycles.
- a and b are don't-care after capture.
- Arithmetic is unsigned modulo 2^WIDTH; bout=1 iff a < b+bin.
- count never exceeds WIDTH-1; no wrap-around.

Optional Feature:
Macro: SERIAL_SUB_FLAGS_EN
- Defined: adds two output ports, each 1 bit, valid and held alongside diff, and cleared on reset:
  - zero: high when diff == 0. Tracked serially as an OR of the shifted-in bits, not a wide compare.
  - ovf: two's-complement overflow, = (a[MSB] ^ b[MSB]) & (diff[MSB] ^ a[MSB]), using MSBs captured at start.
- Undefined: neither port exists and no extra flops are built.

Decomposition:
- Package serial_sub_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - function for the 1-bit difference/borrow equations, shared by RTL and scoreboard.
- Sub-module full_sub_cell: combinational 1-bit full subtractor (a, b, bin → diff, borrow). Instantiated once; the borrow flop stays in the controller.

Test Plan:
- WIDTH=8, a=8'h05, b=8'h03, bin=0, start pulse → done 9 cycles after start edge; diff=8'h02, bout=0, busy high 8 cycles.
- a=8'h03, b=8'h05, bin=0 → diff=8'hFE, bout=1. Then a=8'h00, b=8'h00, bin=1 → diff=8'hFF, bout=1.
- start held high continuously, a=8'h10, b=8'h01 → operations complete every 10 cycles with diff=8'h0F each time. Operands changed during SHIFT do not alter the result.
- rst asserted 4 cycles into SHIFT → next cycle IDLE, ready=1, diff=0, bout=0, no done pulse; new start completes correctly.
- With SERIAL_SUB_FLAGS_EN:
  - a=8'h80, b=8'h01 → diff=8'h7F, ovf=1, zero=0.
  - a=8'h2A, b=8'h2A → diff=0, zero=1, ovf=0.
- Random sweep of 1000 operand/bin triples → diff and bout match scoreboard {bout,diff} = {1'b0,a} - b - bin modulo 2^(WIDTH+1).

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: state encoding and 1-bit full-subtract equations for serial_sub_ctrl
package serial_sub_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  function automatic logic [1:0] fsub(input logic a, input logic b, input logic bin);
    return {(~a & b) | (~(a ^ b) & bin), a ^ b ^ bin};
  endfunction
endpackage

// File: rtl/serial_sub_ctrl_if.sv
// serial_sub_ctrl_if: start/ready/busy/done operand and result bundle; zero/ovf exist only with SERIAL_SUB_FLAGS_EN
interface serial_sub_ctrl_if #(parameter int WIDTH = 8);
  logic start, bin, ready, busy, done, bout;
  logic [WIDTH-1:0] a, b, diff;
`ifdef SERIAL_SUB_FLAGS_EN
  logic zero, ovf;
  modport master (output start, a, b, bin, input ready, busy, done, diff, bout, zero, ovf);
  modport slave (input start, a, b, bin, output ready, busy, done, diff, bout, zero, ovf);
`else
  modport master (output start, a, b, bin, input ready, busy, done, diff, bout);
  modport slave (input start, a, b, bin, output ready, busy, done, diff, bout);
`endif
endinterface

// File: rtl/full_sub_cell.sv
// full_sub_cell: combinational 1-bit full subtractor
module full_sub_cell
  import serial_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic borrow
);
  always_comb {borrow, diff} = fsub(a, b, bin);
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a-b-bin sequencer, LSB first; SERIAL_SUB_FLAGS_EN adds zero/ovf outputs
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic clk,
  input logic rst,
  serial_sub_ctrl_if.slave s
);
  logic [1:0] state;
  logic [WIDTH-1:0] a_sr, b_sr, diff_r;
  logic [CNT_W-1:0] cnt;
  logic borrow_r, bout_r, d, borrow_n, last;
  full_sub_cell u_cell (.a(a_sr[0]), .b(b_sr[0]), .bin(borrow_r), .diff(d), .borrow(borrow_n));
  assign last = cnt == CNT_W'(WIDTH - 1);
  assign s.ready = state == ST_IDLE;
  assign s.busy = state == ST_SHIFT;
  assign s.done = state == ST_DONE;
  assign s.diff = diff_r;
  assign s.bout = bout_r;
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      a_sr <= '0;
      b_sr <= '0;
      diff_r <= '0;
      cnt <= '0;
      borrow_r <= 1'b0;
      bout_r <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (s.start) begin
        a_sr <= s.a;
        b_sr <= s.b;
        borrow_r <= s.bin;
        cnt <= '0;
        diff_r <= '0;
        bout_r <= 1'b0;
        state <= ST_SHIFT;
      end
    end else if (state == ST_SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      diff_r <= {d, diff_r[WIDTH-1:1]};
      borrow_r <= borrow_n;
      cnt <= last ? cnt : cnt + CNT_W'(1);
      bout_r <= last ? borrow_n : bout_r;
      state <= last ? ST_DONE : ST_SHIFT;
    end else begin
      state <= ST_IDLE;
    end
`ifdef SERIAL_SUB_FLAGS_EN
  logic am, bm, any_r, zero_r, ovf_r;
  assign s.zero = zero_r;
  assign s.ovf = ovf_r;
  always_ff @(posedge clk)
    if (rst) begin
      am <= 1'b0;
      bm <= 1'b0;
      any_r <= 1'b0;
      zero_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (state == ST_IDLE && s.start) begin
      am <= s.a[WIDTH-1];
      bm <= s.b[WIDTH-1];
      any_r <= 1'b0;
      zero_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (state == ST_SHIFT) begin
      any_r <= any_r | d;
      zero_r <= last ? ~(any_r | d) : zero_r;
      ovf_r <= last ? (am ^ bm) & (d ^ am) : ovf_r;
    end
`endif
endmodule
